// File: rtl/dff_debounce_edge.sv
// Debouncer: two-flop synchronizer into a confirm FSM. It produces a registered level,
// one-cycle rise/fall pulses and a wrapping count of accepted transitions.
module dff_debounce_edge #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d,
    output logic       q,
    output logic       rise,
    output logic       fall,
    output logic [7:0] edge_count
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        CONF_HIGH = 2'd1,
        HIGH      = 2'd2,
        CONF_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1, s2;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rise_n, fall_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            state      <= LOW;
            cnt        <= '0;
            q          <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            edge_count <= 8'd0;
        end else begin
            s1    <= d;
            s2    <= s1;
            state <= state_n;
            cnt   <= cnt_n;
            // q follows the next state so it changes on the same edge as the pulse
            q     <= (state_n == HIGH) || (state_n == CONF_LOW);
            rise  <= rise_n;
            fall  <= fall_n;
            if (rise_n || fall_n)
                edge_count <= edge_count + 8'd1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        unique case (state)
            LOW: begin
                if (s2) begin
                    state_n = CONF_HIGH;
                    cnt_n   = '0;
                end
            end
            CONF_HIGH: begin
                if (!s2) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = HIGH;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_n = CONF_LOW;
                    cnt_n   = '0;
                end
            end
            CONF_LOW: begin
                if (s2) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = LOW;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dff_debounce_edge.sv
// Bench for dff_debounce_edge: STABLE_CYCLES=4 and STABLE_CYCLES=1 instances share stimulus.
// A run-length model predicts every output each cycle; literal checks pin latencies and counts.
module tb_dff_debounce_edge;

    localparam int SC [2] = '{4, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d   = 1'b0;
    logic       q    [2];
    logic       rise [2];
    logic       fall [2];
    logic [7:0] ec   [2];

    dff_debounce_edge #(.STABLE_CYCLES(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .d(d), .q(q[0]), .rise(rise[0]), .fall(fall[0]), .edge_count(ec[0]));
    dff_debounce_edge #(.STABLE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .d(d), .q(q[1]), .rise(rise[1]), .fall(fall[1]), .edge_count(ec[1]));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // model: d seen through two sample delays; level flips after SC+1 consecutive differing samples
    bit       h1 [2], h2 [2], mq [2], mr [2], mf [2];
    int       run [2];
    bit [7:0] mc [2];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                h1[i] = 0; h2[i] = 0; mq[i] = 0; mr[i] = 0; mf[i] = 0; run[i] = 0; mc[i] = 0;
            end else begin
                bit sv;
                sv = h2[i];
                h2[i] = h1[i];
                h1[i] = d;
                mr[i] = 0;
                mf[i] = 0;
                if (sv != mq[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == SC[i] + 1) begin
                    mq[i] = ~mq[i];
                    run[i] = 0;
                    if (mq[i]) mr[i] = 1;
                    else mf[i] = 1;
                    mc[i] = mc[i] + 8'd1;
                end
            end
        end
    end

    int  last_rise [2];
    int  last_fall [2];
    int  nrise [2];
    int  nfall [2];
    bit  prevp [2];

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({q[i], rise[i], fall[i], ec[i]} !== {mq[i], mr[i], mf[i], mc[i]}) begin
                fails++;
                $display("FAIL model[%0d] cyc %0d: got q=%b r=%b f=%b ec=%0d, want q=%b r=%b f=%b ec=%0d",
                         i, cyc, q[i], rise[i], fall[i], ec[i], mq[i], mr[i], mf[i], mc[i]);
            end
            tests++;
            if ((rise[i] === 1'b1 && fall[i] === 1'b1) || (prevp[i] && (rise[i] === 1'b1 || fall[i] === 1'b1))) begin
                fails++;
                $display("FAIL pulse_excl[%0d] cyc %0d: got r=%b f=%b prev=%b, want isolated single pulses",
                         i, cyc, rise[i], fall[i], prevp[i]);
            end
            prevp[i] = (rise[i] === 1'b1) || (fall[i] === 1'b1);
            if (rise[i] === 1'b1) begin last_rise[i] = cyc; nrise[i]++; end
            if (fall[i] === 1'b1) begin last_fall[i] = cyc; nfall[i]++; end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    int e0;

    task automatic drive(input logic v, input int n);
        @(negedge clk);
        d  = v;
        e0 = cyc + 1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic clr_pulses();
        for (int i = 0; i < 2; i++) begin
            nrise[i] = 0; nfall[i] = 0; last_rise[i] = -1; last_fall[i] = -1;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_q", int'(q[0]), 0);
        check("reset_ec", int'(ec[0]), 0);
        rst = 1'b0;

        // held high
        clr_pulses();
        drive(1'b1, 12);
        check("rise_latency_s4", last_rise[0] - e0, 6);
        check("rise_latency_s1", last_rise[1] - e0, 3);
        check("high_q", int'(q[0]), 1);
        check("high_ec", int'(ec[0]), 1);
        check("high_nofall", nfall[0], 0);

        // held low
        clr_pulses();
        drive(1'b0, 20);
        check("fall_latency", last_fall[0] - e0, 6);
        check("fall_count", nfall[0], 1);
        check("low_q", int'(q[0]), 0);
        check("low_ec", int'(ec[0]), 2);

        // bounce shorter than the stability window
        clr_pulses();
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 1); drive(1'b1, 1); drive(1'b0, 10);
        check("bounce_q", int'(q[0]), 0);
        check("bounce_pulses", nrise[0] + nfall[0], 0);
        check("bounce_ec", int'(ec[0]), 2);

        // clean toggles up to 255, then wrap
        for (int k = 0; k < 253; k++) drive(~d, 8);
        check("ec_255", int'(ec[0]), 255);
        check("q_before_wrap", int'(q[0]), 1);
        clr_pulses();
        drive(1'b0, 8);
        check("ec_wrap", int'(ec[0]), 0);
        check("wrap_fall_latency", last_fall[0] - e0, 6);
        check("wrap_fall_count", nfall[0], 1);

        // reset while confirming a fall
        drive(1'b1, 8);
        drive(1'b0, 4);
        check("conf_low_q", int'(q[0]), 1);
        clr_pulses();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_q", int'(q[0]), 0);
        check("rst_rise", int'(rise[0]), 0);
        check("rst_fall", int'(fall[0]), 0);
        check("rst_ec", int'(ec[0]), 0);
        repeat (10) @(negedge clk);
        check("rst_nofall", nfall[0], 0);
        check("rst_ec_hold", int'(ec[0]), 0);

        // fresh start from LOW after reset
        clr_pulses();
        drive(1'b1, 10);
        check("post_rst_rise_latency", last_rise[0] - e0, 6);
        check("post_rst_ec", int'(ec[0]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
